l2_refill_ctrl: RTL and testbench

L2_REFILL_CTRL -- requirements
Module: l2_refill_ctrl

---
 rtl/cache_ctrl_pkg.sv | 18 +
 rtl/sat_counter.sv | 16 +
 rtl/l2_refill_ctrl.sv | 138 +++++++++++++
 tb/tb_l2_refill_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types for the L2 refill controller: FSM state encoding and prefetch stride.
// The PREFETCH state exists only when L2_PREFETCH_NEXT_EN is defined.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_WAIT,
    FILL,
    RESP
`ifdef L2_PREFETCH_NEXT_EN
    , PREFETCH
`endif
  } refill_state_e;

  localparam int unsigned PF_STRIDE = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the L2 hit/miss statistics; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst)                     cnt <= '0;
    else if (inc && (cnt != '1)) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/l2_refill_ctrl.sv
// L2 refill controller: L1 miss -> L2 lookup -> memory refill -> L2 fill -> response.
// Optional next-line prefetch after a miss when L2_PREFETCH_NEXT_EN is defined.
module l2_refill_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  output logic                  req_ready_o,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_instr_o,
  output logic [ADDR_WIDTH-1:0] l2_addr_o,
  input  logic                  l2_hit_i,
  input  logic [DATA_WIDTH-1:0] l2_instr_i,
  output logic                  l2_fill_o,
  output logic [DATA_WIDTH-1:0] l2_fill_data_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic [CNT_WIDTH-1:0]  hit_cnt_o,
  output logic [CNT_WIDTH-1:0]  miss_cnt_o
);

  refill_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  hit_inc, miss_inc;
`ifdef L2_PREFETCH_NEXT_EN
  logic                  miss_q;  // current request went to memory
  logic                  pf_q;    // FILL belongs to a prefetch, not a demand miss
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    case (state_q)
      IDLE:     if (req_valid_i) state_d = LOOKUP;
      LOOKUP: begin
        if (l2_hit_i) begin
          hit_inc = 1'b1;
          state_d = RESP;
        end else begin
          miss_inc = 1'b1;
          state_d  = MEM_WAIT;
        end
      end
      MEM_WAIT: if (mem_ack_i) state_d = FILL;
`ifdef L2_PREFETCH_NEXT_EN
      FILL:     state_d = pf_q ? IDLE : RESP;
      RESP:     state_d = miss_q ? PREFETCH : IDLE;
      PREFETCH: if (mem_ack_i) state_d = FILL;
`else
      FILL:     state_d = RESP;
      RESP:     state_d = IDLE;
`endif
      default:  state_d = IDLE;
    endcase
  end

  // Address/data capture; in prefetch the latched address advances so both
  // mem_addr_o and l2_addr_o point at the next line.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
`ifdef L2_PREFETCH_NEXT_EN
      miss_q <= 1'b0;
      pf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          addr_q <= req_addr_i;
`ifdef L2_PREFETCH_NEXT_EN
          miss_q <= 1'b0;
          pf_q   <= 1'b0;
`endif
        end
        LOOKUP: begin
          if (l2_hit_i) data_q <= l2_instr_i;
`ifdef L2_PREFETCH_NEXT_EN
          else          miss_q <= 1'b1;
`endif
        end
        MEM_WAIT: if (mem_ack_i) data_q <= mem_data_i;
`ifdef L2_PREFETCH_NEXT_EN
        RESP: if (miss_q) begin
          addr_q <= addr_q + ADDR_WIDTH'(PF_STRIDE);
          pf_q   <= 1'b1;
        end
        PREFETCH: if (mem_ack_i) data_q <= mem_data_i;
`endif
        default: ;
      endcase
    end
  end

  sat_counter #(.W(CNT_WIDTH)) u_hit_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit_inc),
    .cnt (hit_cnt_o)
  );

  sat_counter #(.W(CNT_WIDTH)) u_miss_cnt (
    .clk (clk),
    .rst (rst),
    .inc (miss_inc),
    .cnt (miss_cnt_o)
  );

  // Ready is masked while reset is still held so nothing is accepted mid-reset.
  assign req_ready_o    = (state_q == IDLE) && !rst;
  assign resp_valid_o   = (state_q == RESP);
  assign resp_instr_o   = data_q;
  assign l2_addr_o      = addr_q;
  assign l2_fill_o      = (state_q == FILL);
  assign l2_fill_data_o = data_q;
`ifdef L2_PREFETCH_NEXT_EN
  assign mem_req_o      = (state_q == MEM_WAIT) || (state_q == PREFETCH);
`else
  assign mem_req_o      = (state_q == MEM_WAIT);
`endif
  assign mem_addr_o     = addr_q;

endmodule

// File: tb/tb_l2_refill_ctrl.sv
// Directed self-checking bench for l2_refill_ctrl; a second instance with 2-bit
// counters shares all inputs to exercise counter saturation cheaply.
module tb_l2_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        l2_hit;
  logic [31:0] l2_instr;
  logic        mem_ack;
  logic [31:0] mem_data;

  logic        req_ready, resp_valid, l2_fill, mem_req;
  logic [31:0] resp_instr, l2_addr, l2_fill_data, mem_addr;
  logic [15:0] hit_cnt, miss_cnt;

  logic        s_req_ready, s_resp_valid, s_l2_fill, s_mem_req;
  logic [31:0] s_resp_instr, s_l2_addr, s_l2_fill_data, s_mem_addr;
  logic [1:0]  s_hit_cnt, s_miss_cnt;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  l2_refill_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(req_ready),
    .resp_valid_o(resp_valid), .resp_instr_o(resp_instr),
    .l2_addr_o(l2_addr), .l2_hit_i(l2_hit), .l2_instr_i(l2_instr),
    .l2_fill_o(l2_fill), .l2_fill_data_o(l2_fill_data),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack), .mem_data_i(mem_data),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  l2_refill_ctrl #(.CNT_WIDTH(2)) dut_s (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(s_req_ready),
    .resp_valid_o(s_resp_valid), .resp_instr_o(s_resp_instr),
    .l2_addr_o(s_l2_addr), .l2_hit_i(l2_hit), .l2_instr_i(l2_instr),
    .l2_fill_o(s_l2_fill), .l2_fill_data_o(s_l2_fill_data),
    .mem_req_o(s_mem_req), .mem_addr_o(s_mem_addr), .mem_ack_i(mem_ack), .mem_data_i(mem_data),
    .hit_cnt_o(s_hit_cnt), .miss_cnt_o(s_miss_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // L2-hit transaction; response must appear two cycles after acceptance.
  task automatic hit_txn(input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_addr = a; l2_hit = 1'b1; l2_instr = d;
    #1 chk("hit_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("hit_lookup_no_resp", resp_valid, 0);
    tick();
    chk("hit_resp_valid", resp_valid, 1);
    chk("hit_resp_instr", resp_instr, d);
    chk("hit_no_mem_req", mem_req, 0);
    chk("s_hit_resp_instr", s_resp_instr, d);
    tick();
    chk("hit_back_idle", req_ready, 1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; l2_hit = 1'b0; l2_instr = '0;
    mem_ack = 1'b0; mem_data = '0;

    // Reset state
    tick(); tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_fill", l2_fill, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    rst = 1'b0;
    #1 chk("ready_after_rst", req_ready, 1);

    // Hit at 0x100
    hit_txn(32'h0000_0100, 32'h0010_0093);
    chk("hit_cnt_1", hit_cnt, 1);
    chk("miss_cnt_0", miss_cnt, 0);

    // Miss at 0x200 with a second request held behind it
    req_valid = 1'b1; req_addr = 32'h0000_0200; l2_hit = 1'b0;
    tick();
    req_addr = 32'h0000_0300;
    chk("b2b_ready_lookup", req_ready, 0);
    chk("miss_l2_addr", l2_addr, 32'h0000_0200);
    tick();
    chk("miss_mem_req", mem_req, 1);
    chk("miss_mem_addr", mem_addr, 32'h0000_0200);
    chk("miss_cnt_1", miss_cnt, 1);
    chk("b2b_ready_wait", req_ready, 0);
    tick();
    chk("miss_mem_req_hold1", mem_req, 1);
    tick();
    chk("miss_mem_req_hold2", mem_req, 1);
    chk("miss_mem_addr_hold", mem_addr, 32'h0000_0200);
    tick();
    chk("miss_no_fill_yet", l2_fill, 0);
    mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0; mem_data = '0;
    chk("miss_fill", l2_fill, 1);
    chk("miss_fill_data", l2_fill_data, 32'hDEAD_BEEF);
    chk("miss_mem_req_drop", mem_req, 0);
    chk("miss_no_resp_in_fill", resp_valid, 0);
    l2_hit = 1'b1; l2_instr = 32'h1234_5678;
    tick();
    chk("miss_fill_one_cycle", l2_fill, 0);
    chk("miss_resp_valid", resp_valid, 1);
    chk("miss_resp_instr", resp_instr, 32'hDEAD_BEEF);
    chk("b2b_ready_resp", req_ready, 0);
    tick();
`ifdef L2_PREFETCH_NEXT_EN
    chk("pf_b2b_ready", req_ready, 0);
    chk("pf_b2b_mem_addr", mem_addr, 32'h0000_0204);
    mem_ack = 1'b1; mem_data = 32'h0BAD_F00D;
    tick();
    mem_ack = 1'b0;
    chk("pf_b2b_fill", l2_fill, 1);
    chk("pf_b2b_l2_addr", l2_addr, 32'h0000_0204);
    tick();
`endif
    chk("b2b_ready_again", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("b2b_l2_addr", l2_addr, 32'h0000_0300);
    tick();
    chk("b2b_resp_valid", resp_valid, 1);
    chk("b2b_resp_instr", resp_instr, 32'h1234_5678);
    chk("b2b_hit_cnt", hit_cnt, 2);
    chk("b2b_miss_cnt", miss_cnt, 1);
    tick();

    // mem_ack outside MEM_WAIT is ignored
    mem_ack = 1'b1; mem_data = 32'h5555_AAAA;
    tick();
    chk("stray_ack_fill", l2_fill, 0);
    tick();
    chk("stray_ack_resp", resp_valid, 0);
    chk("stray_ack_ready", req_ready, 1);
    mem_ack = 1'b0;

    // Reset in the middle of MEM_WAIT
    req_valid = 1'b1; req_addr = 32'h0000_0400; l2_hit = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rmw_mem_req", mem_req, 1);
    chk("rmw_miss_cnt", miss_cnt, 2);
    rst = 1'b1;
    tick();
    chk("rmw_mem_req_0", mem_req, 0);
    chk("rmw_ready_0", req_ready, 0);
    chk("rmw_hit_cnt_0", hit_cnt, 0);
    chk("rmw_miss_cnt_0", miss_cnt, 0);
    chk("rmw_l2_addr_0", l2_addr, 0);
    chk("rmw_mem_addr_0", mem_addr, 0);
    chk("rmw_resp_instr_0", resp_instr, 0);
    chk("rmw_fill_data_0", l2_fill_data, 0);
    rst = 1'b0; mem_ack = 1'b1; mem_data = 32'hCAFE_0001;
    #1 chk("rmw_ready_after", req_ready, 1);
    tick();
    chk("rmw_late_ack_fill", l2_fill, 0);
    tick();
    chk("rmw_late_ack_resp", resp_valid, 0);
    chk("rmw_late_ack_fill2", l2_fill, 0);
    mem_ack = 1'b0;

    // Counter saturation (2-bit instance saturates at 3)
    hit_txn(32'h0000_1000, 32'hA000_0001);
    hit_txn(32'h0000_1004, 32'hA000_0002);
    hit_txn(32'h0000_1008, 32'hA000_0003);
    chk("sat_small_at_max", s_hit_cnt, 3);
    hit_txn(32'h0000_100C, 32'hA000_0004);
    chk("sat_small_held", s_hit_cnt, 3);
    chk("sat_wide_cnt", hit_cnt, 4);

    // Miss at the top of the address space
    req_valid = 1'b1; req_addr = 32'hFFFF_FFFC; l2_hit = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    chk("top_miss_cnt", miss_cnt, 1);
    mem_ack = 1'b1; mem_data = 32'h1111_1111;
    tick();
    mem_ack = 1'b0;
    chk("top_fill_data", l2_fill_data, 32'h1111_1111);
    tick();
    chk("top_resp_instr", resp_instr, 32'h1111_1111);
    tick();
`ifdef L2_PREFETCH_NEXT_EN
    chk("pf_mem_req", mem_req, 1);
    chk("pf_mem_addr_wrap", mem_addr, 32'h0000_0000);
    chk("pf_ready_0", req_ready, 0);
    mem_ack = 1'b1; mem_data = 32'h2222_2222;
    tick();
    mem_ack = 1'b0;
    chk("pf_fill", l2_fill, 1);
    chk("pf_fill_data", l2_fill_data, 32'h2222_2222);
    chk("pf_l2_addr", l2_addr, 32'h0000_0000);
    chk("pf_no_resp", resp_valid, 0);
    tick();
    chk("pf_fill_once", l2_fill, 0);
    chk("pf_miss_cnt", miss_cnt, 1);
    chk("pf_hit_cnt", hit_cnt, 4);
`else
    chk("nopf_mem_req", mem_req, 0);
    chk("nopf_fill", l2_fill, 0);
`endif
    chk("top_ready_end", req_ready, 1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
